// File: rtl/demux_scan_driver.sv
// rtl/demux_scan_driver.sv - buffers a 16-bit word and scans it onto a 1-to-16 demux select/data pair
module demux_scan_driver #(
    parameter int DWELL = 1,
    parameter int DW_W  = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] word,
    input  logic        dav,
    output logic        rfd,
    output logic        x0,
    output logic [3:0]  b3_b0,
    output logic        busy,
    output logic        done
);

    // A dwell of zero would give no visible channel, so it behaves as one cycle.
    localparam int              DW_EFF   = (DWELL < 1) ? 1 : DWELL;
    localparam logic [DW_W-1:0] CNT_LOAD = DW_W'(DW_EFF - 1);
    localparam logic [DW_W-1:0] CNT_ONE  = DW_W'(1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_END  = 2'd2;

    logic [1:0]      state;
    logic [15:0]     data_buf;
    logic [DW_W-1:0] cnt;
    logic [3:0]      next_sel;

    // Channel that follows the one currently presented; only used before channel 15.
    always_comb begin
        next_sel = b3_b0 + 4'd1;
    end

    // Handshake, scan sequencing and all registered outputs; x0 and b3_b0 always move together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            rfd      <= 1'b1;
            x0       <= 1'b0;
            b3_b0    <= 4'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            data_buf <= 16'd0;
            cnt      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dav) begin
                        data_buf <= word;
                        b3_b0    <= 4'd0;
                        x0       <= word[0];
                        cnt      <= CNT_LOAD;
                        rfd      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else if (b3_b0 != 4'd15) begin
                        b3_b0 <= next_sel;
                        x0    <= data_buf[next_sel];
                        cnt   <= CNT_LOAD;
                    end else begin
                        x0    <= 1'b0;
                        b3_b0 <= 4'd0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_END;
                    end
                end
                ST_END: begin
                    done <= 1'b0;
                    // A dav still held from the last accept must drop before another word is taken.
                    if (!dav) begin
                        rfd   <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    rfd   <= 1'b1;
                    x0    <= 1'b0;
                    b3_b0 <= 4'd0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_scan_driver.sv
// tb/tb_demux_scan_driver.sv - directed bench with a cycle-position model for DWELL=1 and DWELL=3
module tb_demux_scan_driver;

    logic        clock;
    logic        reset;
    logic [15:0] word_v [2];
    logic        dav_v  [2];
    logic        rfd_v  [2];
    logic        x0_v   [2];
    logic [3:0]  b_v    [2];
    logic        busy_v [2];
    logic        done_v [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    demux_scan_driver #(.DWELL(1), .DW_W(4)) u_d1 (
        .clock(clock), .reset(reset), .word(word_v[0]), .dav(dav_v[0]),
        .rfd(rfd_v[0]), .x0(x0_v[0]), .b3_b0(b_v[0]), .busy(busy_v[0]), .done(done_v[0])
    );

    demux_scan_driver #(.DWELL(3), .DW_W(4)) u_d3 (
        .clock(clock), .reset(reset), .word(word_v[1]), .dav(dav_v[1]),
        .rfd(rfd_v[1]), .x0(x0_v[1]), .b3_b0(b_v[1]), .busy(busy_v[1]), .done(done_v[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int dwell_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    // Model: position k (1-based) inside a scan determines channel (k-1)/DWELL directly.
    int          md [2];
    int          kk [2];
    logic        fe [2];
    logic [15:0] mw [2];

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                md[i] <= 0;
                kk[i] <= 0;
                fe[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                case (md[i])
                    0: if (dav_v[i]) begin
                        mw[i] <= word_v[i];
                        kk[i] <= 1;
                        md[i] <= 1;
                    end
                    1: if (kk[i] == 16 * dwell_of(i)) begin
                        md[i] <= 2;
                        fe[i] <= 1'b1;
                    end else begin
                        kk[i] <= kk[i] + 1;
                    end
                    default: begin
                        fe[i] <= 1'b0;
                        if (!dav_v[i]) md[i] <= 0;
                    end
                endcase
            end
        end
    end

    function automatic logic [7:0] model_out(input int i);
        int ch;
        if (md[i] == 0) return 8'b1_0_0000_0_0;
        if (md[i] == 1) begin
            ch = (kk[i] - 1) / dwell_of(i);
            return {1'b0, mw[i][ch], 4'(ch), 1'b1, 1'b0};
        end
        return {1'b0, 1'b0, 4'd0, 1'b0, fe[i]};
    endfunction

    // Every cycle, both instances against the model.
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_inst%0d", i),
                {8'd0, rfd_v[i], x0_v[i], b_v[i], busy_v[i], done_v[i]},
                {8'd0, model_out(i)});
        end
    end

    int seq_a5c3 [16] = '{1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1};
    int t_first;

    task automatic neg(input int n);
        for (int j = 0; j < n; j++) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dav_v[i]  = 1'b0;
            word_v[i] = 16'd0;
        end
        neg(1);
        for (int i = 0; i < 2; i++) begin
            chk("reset_rfd",  {15'd0, rfd_v[i]},  16'd1);
            chk("reset_x0",   {15'd0, x0_v[i]},   16'd0);
            chk("reset_sel",  {12'd0, b_v[i]},    16'd0);
            chk("reset_busy", {15'd0, busy_v[i]}, 16'd0);
            chk("reset_done", {15'd0, done_v[i]}, 16'd0);
        end
        reset = 1'b0;
        neg(2);

        // T2: DWELL=1, A5C3
        word_v[0] = 16'hA5C3;
        dav_v[0]  = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            neg(1);
            if (c == 1) begin
                chk("t2_rfd_low", {15'd0, rfd_v[0]}, 16'd0);
                dav_v[0] = 1'b0;
            end
            chk("t2_sel", {12'd0, b_v[0]}, 16'(c - 1));
            chk("t2_x0", {15'd0, x0_v[0]}, 16'(seq_a5c3[c-1]));
        end
        neg(1);
        chk("t2_done", {15'd0, done_v[0]}, 16'd1);
        chk("t2_end_sel", {12'd0, b_v[0]}, 16'd0);
        neg(1);
        chk("t2_rfd_back", {15'd0, rfd_v[0]}, 16'd1);
        chk("t2_done_clr", {15'd0, done_v[0]}, 16'd0);

        // T3 + T6: DWELL=3, 8001 then back-to-back 0F0F
        word_v[1] = 16'h8001;
        dav_v[1]  = 1'b1;
        for (int c = 1; c <= 48; c++) begin
            neg(1);
            if (c == 1) begin
                t_first = cyc;
                dav_v[1] = 1'b0;
            end
            chk("t3_sel", {12'd0, b_v[1]}, 16'((c - 1) / 3));
            chk("t3_x0", {15'd0, x0_v[1]},
                (((c - 1) / 3 == 0) || ((c - 1) / 3 == 15)) ? 16'd1 : 16'd0);
        end
        neg(1);
        chk("t3_done49", {15'd0, done_v[1]}, 16'd1);
        neg(1);
        chk("t6_rfd_idle", {15'd0, rfd_v[1]}, 16'd1);
        word_v[1] = 16'h0F0F;
        dav_v[1]  = 1'b1;
        neg(1);
        chk("t6_busy", {15'd0, busy_v[1]}, 16'd1);
        chk("t6_x0", {15'd0, x0_v[1]}, 16'd1);
        chk("t6_period", 16'(cyc - t_first), 16'd50);
        dav_v[1] = 1'b0;
        neg(52);
        chk("t6_idle", {15'd0, rfd_v[1]}, 16'd1);

        // T4: dav held through END blocks a second scan
        word_v[0] = 16'h1234;
        dav_v[0]  = 1'b1;
        neg(17);
        chk("t4_done", {15'd0, done_v[0]}, 16'd1);
        for (int c = 0; c < 5; c++) begin
            neg(1);
            chk("t4_rfd_held", {15'd0, rfd_v[0]}, 16'd0);
            chk("t4_no_rescan", {15'd0, busy_v[0]}, 16'd0);
        end
        dav_v[0] = 1'b0;
        neg(1);
        chk("t4_rfd_release", {15'd0, rfd_v[0]}, 16'd1);

        // T5: word and dav churn during a scan of 0000
        word_v[0] = 16'h0000;
        dav_v[0]  = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            neg(1);
            word_v[0] = 16'hFFFF;
            dav_v[0]  = (c == 16) ? 1'b0 : ~dav_v[0];
            chk("t5_x0_zero", {15'd0, x0_v[0]}, 16'd0);
        end
        neg(2);
        chk("t5_idle", {15'd0, rfd_v[0]}, 16'd1);

        // T1: asynchronous reset at channel 7, then dav already high at release
        word_v[0] = 16'hFFFF;
        dav_v[0]  = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            neg(1);
            if (c == 1) dav_v[0] = 1'b0;
        end
        chk("t1_at_ch7", {12'd0, b_v[0]}, 16'd7);
        dav_v[0] = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("t1_async_x0",   {15'd0, x0_v[0]},   16'd0);
        chk("t1_async_sel",  {12'd0, b_v[0]},    16'd0);
        chk("t1_async_rfd",  {15'd0, rfd_v[0]},  16'd1);
        chk("t1_async_busy", {15'd0, busy_v[0]}, 16'd0);
        neg(2);
        reset = 1'b0;
        neg(1);
        chk("t1_first_accept_busy", {15'd0, busy_v[0]}, 16'd1);
        chk("t1_first_accept_sel", {12'd0, b_v[0]}, 16'd0);
        dav_v[0] = 1'b0;
        neg(20);
        chk("t1_final_idle", {15'd0, rfd_v[0]}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
